// File: rtl/algo_2ru_err_log_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : algo_err_pkg
//  Brief    : Shared types, sizes and helpers for the read-error log stage.
//  Revision : 1.0 - initial release
// ============================================================================
package algo_err_pkg;

   localparam int c_NUMRUPT = 2;
   localparam int c_BITPADR = 13;
   localparam int c_LOGDPTH = 8;
   localparam int c_BITLOG  = 3;
   localparam int c_CNTWDTH = 16;

   // Derived widths: port index, per-cycle increment, packed log entry
   localparam int c_PORTW   = (c_NUMRUPT > 1) ? $clog2(c_NUMRUPT) : 1;
   localparam int c_INCW    = $clog2(c_NUMRUPT + 1);
   localparam int c_ENTW    = c_PORTW + 1 + c_BITPADR;

   typedef struct packed {
      logic [c_PORTW-1:0]  port;
      logic                derr;
      logic [c_BITPADR-1:0] padr;
   } err_entry_t;

   // Add a small per-cycle increment, sticking at all-ones instead of wrapping
   function automatic logic [c_CNTWDTH-1:0] satAdd(
      input logic [c_CNTWDTH-1:0] base,
      input logic [c_INCW-1:0]    inc
   );
      logic [c_CNTWDTH:0] sum;
      sum = {1'b0, base} + {{(c_CNTWDTH + 1 - c_INCW){1'b0}}, inc};
      return sum[c_CNTWDTH] ? {c_CNTWDTH{1'b1}} : sum[c_CNTWDTH-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/algo_2ru_err_log_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : infra_fifo_mw
//  Brief    : Multi-write, single-read FIFO. Pushes arrive already compacted
//             into the low slots; the writer guarantees they fit.
//  Revision : 1.0 - initial release
// ============================================================================
module infra_fifo_mw #(
   parameter int NUMW  = 2,
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int DW    = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUMW-1:0]    pushVld,
   input  logic [NUMW*DW-1:0] pushData,
   input  logic               pop,
   output logic [DW-1:0]      head,
   output logic [AW:0]        level
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_level;
   logic [AW:0]   w_nPush;
   logic          w_popEff;
   logic [AW-1:0] w_wrIdx [NUMW];

   // Count the pushes this cycle
   always_comb begin
      w_nPush = '0;
      for (int k = 0; k < NUMW; k++) begin
         if (pushVld[k]) w_nPush = w_nPush + (AW + 1)'(1);
      end
   end

   assign w_popEff = pop & (r_level != '0);

   // Slot k lands k entries past the write pointer, wrapping modulo DEPTH
   for (genvar k = 0; k < NUMW; k++) begin : g_wrIdx
      assign w_wrIdx[k] = r_wrPtr + AW'(k);
   end

   // Storage write; no reset needed since the head is qualified by level
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUMW; k++) begin
         if (pushVld[k]) r_mem[w_wrIdx[k]] <= pushData[k*DW +: DW];
      end
   end

   // Pointer and occupancy update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         r_wrPtr <= r_wrPtr + w_nPush[AW-1:0];
         r_rdPtr <= r_rdPtr + AW'(w_popEff);
         r_level <= r_level + w_nPush - (AW + 1)'(w_popEff);
      end
   end

   assign head  = r_mem[r_rdPtr];
   assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/algo_2ru_err_log.sv
`default_nettype none
// ============================================================================
//  Module   : algo_2ru_err_log
//  Brief    : Captures erroneous read responses into a small log FIFO and
//             keeps saturating error/drop statistics plus a level interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module algo_2ru_err_log
   import algo_err_pkg::*;
#(
   parameter int NUMRUPT = c_NUMRUPT,
   parameter int BITPADR = c_BITPADR,
   parameter int LOGDPTH = c_LOGDPTH,
   parameter int BITLOG  = c_BITLOG,
   parameter int CNTWDTH = c_CNTWDTH
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        ready,
   input  logic [NUMRUPT-1:0]                          rd_vld,
   input  logic [NUMRUPT-1:0]                          rd_serr,
   input  logic [NUMRUPT-1:0]                          rd_derr,
   input  logic [NUMRUPT*BITPADR-1:0]                  rd_padr,
   output logic                                        log_vld,
   output logic [((NUMRUPT > 1) ? $clog2(NUMRUPT) : 1)-1:0] log_port,
   output logic                                        log_derr,
   output logic [BITPADR-1:0]                          log_padr,
   input  logic                                        log_pop,
   output logic [BITLOG:0]                             log_lvl,
   output logic [CNTWDTH-1:0]                          serr_cnt,
   output logic [CNTWDTH-1:0]                          derr_cnt,
   output logic [CNTWDTH-1:0]                          drop_cnt,
   output logic                                        ovfl,
   input  logic                                        cnt_clr,
   output logic                                        irq
);

   localparam int c_SPW = BITLOG + 1;

   logic [NUMRUPT-1:0]        w_evt;
   err_entry_t                w_entry [NUMRUPT];
   logic [NUMRUPT-1:0]        w_pushVld;
   logic [NUMRUPT*c_ENTW-1:0] w_pushData;
   logic [c_ENTW-1:0]         w_headVec;
   err_entry_t                w_head;
   logic [BITLOG:0]           w_lvl;
   logic [BITLOG:0]           w_space;
   logic [BITLOG:0]           w_lvlNext;
   logic                      w_headVld;
   logic                      w_popEff;
   logic                      w_ovflNext;
   logic [c_INCW-1:0]         w_nAcc;
   logic [c_INCW-1:0]         w_nDrop;
   logic [c_INCW-1:0]         w_nSerr;
   logic [c_INCW-1:0]         w_nDerr;
   logic [CNTWDTH-1:0]        r_serrCnt;
   logic [CNTWDTH-1:0]        r_derrCnt;
   logic [CNTWDTH-1:0]        r_dropCnt;
   logic                      r_ovfl;
   logic                      r_irq;

   // Per-port event qualification and entry formation; forward flag kept as-is
   for (genvar p = 0; p < NUMRUPT; p++) begin : g_evt
      assign w_evt[p]   = ready & rd_vld[p] & (rd_serr[p] | rd_derr[p]);
      assign w_entry[p] = '{port: c_PORTW'(p),
                            derr: rd_derr[p],
                            padr: rd_padr[p*BITPADR +: BITPADR]};
   end

   assign w_headVld = (w_lvl != '0);
   assign w_popEff  = log_pop & w_headVld;
   // A same-cycle pop frees its slot for this cycle's pushes
   assign w_space   = c_SPW'(LOGDPTH) - w_lvl + c_SPW'(w_popEff);

   // Compact events into low slots in port order; overflow beyond space drops
   always_comb begin
      w_pushVld  = '0;
      w_pushData = '0;
      w_nAcc     = '0;
      w_nDrop    = '0;
      w_nSerr    = '0;
      w_nDerr    = '0;
      for (int p = 0; p < NUMRUPT; p++) begin
         if (w_evt[p]) begin
            if (rd_derr[p]) w_nDerr = w_nDerr + c_INCW'(1);
            else            w_nSerr = w_nSerr + c_INCW'(1);
            if (c_SPW'(w_nAcc) < w_space) begin
               for (int k = 0; k < NUMRUPT; k++) begin
                  if (c_INCW'(k) == w_nAcc) begin
                     w_pushVld[k]                  = 1'b1;
                     w_pushData[k*c_ENTW +: c_ENTW] = w_entry[p];
                  end
               end
               w_nAcc = w_nAcc + c_INCW'(1);
            end else begin
               w_nDrop = w_nDrop + c_INCW'(1);
            end
         end
      end
   end

   infra_fifo_mw #(
      .NUMW  (NUMRUPT),
      .DEPTH (LOGDPTH),
      .AW    (BITLOG),
      .DW    (c_ENTW)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .pushVld  (w_pushVld),
      .pushData (w_pushData),
      .pop      (w_popEff),
      .head     (w_headVec),
      .level    (w_lvl)
   );

   assign w_head     = w_headVec;
   assign w_lvlNext  = w_lvl + c_SPW'(w_nAcc) - c_SPW'(w_popEff);
   assign w_ovflNext = cnt_clr ? 1'b0 : (r_ovfl | (w_nDrop != '0));

   // Saturating statistics; clear takes priority over same-cycle events
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_serrCnt <= '0;
         r_derrCnt <= '0;
         r_dropCnt <= '0;
      end else if (cnt_clr) begin
         r_serrCnt <= '0;
         r_derrCnt <= '0;
         r_dropCnt <= '0;
      end else begin
         r_serrCnt <= satAdd(r_serrCnt, w_nSerr);
         r_derrCnt <= satAdd(r_derrCnt, w_nDerr);
         r_dropCnt <= satAdd(r_dropCnt, w_nDrop);
      end
   end

   // Sticky overflow and registered interrupt built from next-state values
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovfl <= 1'b0;
         r_irq  <= 1'b0;
      end else begin
         r_ovfl <= w_ovflNext;
         r_irq  <= (w_lvlNext != '0) | w_ovflNext;
      end
   end

   assign log_vld  = w_headVld;
   assign log_port = w_headVld ? w_head.port : '0;
   assign log_derr = w_headVld & w_head.derr;
   assign log_padr = w_headVld ? w_head.padr : '0;
   assign log_lvl  = w_lvl;
   assign serr_cnt = r_serrCnt;
   assign derr_cnt = r_derrCnt;
   assign drop_cnt = r_dropCnt;
   assign ovfl     = r_ovfl;
   assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_algo_2ru_err_log.sv
`default_nettype none
// ============================================================================
//  Module   : tb_algo_2ru_err_log
//  Brief    : Directed self-checking bench for the read-error log stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_algo_2ru_err_log;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic [1:0]  rd_vld;
   logic [1:0]  rd_serr;
   logic [1:0]  rd_derr;
   logic [25:0] rd_padr;
   logic        log_vld;
   logic [0:0]  log_port;
   logic        log_derr;
   logic [12:0] log_padr;
   logic        log_pop;
   logic [3:0]  log_lvl;
   logic [15:0] serr_cnt;
   logic [15:0] derr_cnt;
   logic [15:0] drop_cnt;
   logic        ovfl;
   logic        cnt_clr;
   logic        irq;

   int checks = 0;
   int errors = 0;

   algo_2ru_err_log dut (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .rd_vld   (rd_vld),
      .rd_serr  (rd_serr),
      .rd_derr  (rd_derr),
      .rd_padr  (rd_padr),
      .log_vld  (log_vld),
      .log_port (log_port),
      .log_derr (log_derr),
      .log_padr (log_padr),
      .log_pop  (log_pop),
      .log_lvl  (log_lvl),
      .serr_cnt (serr_cnt),
      .derr_cnt (derr_cnt),
      .drop_cnt (drop_cnt),
      .ovfl     (ovfl),
      .cnt_clr  (cnt_clr),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] s, input logic [1:0] d,
                        input logic [12:0] a1, input logic [12:0] a0);
      rd_vld  = v;
      rd_serr = s;
      rd_derr = d;
      rd_padr = {a1, a0};
   endtask

   task automatic idle();
      drive(2'b00, 2'b00, 2'b00, 13'h0, 13'h0);
   endtask

   task automatic test_reset();
      #2;
      checks++; if (log_vld !== 1'b0)  begin errors++; $display("FAIL rst_vld: got %0d expected 0", log_vld); end
      checks++; if (log_lvl !== 4'd0)  begin errors++; $display("FAIL rst_lvl: got %0d expected 0", log_lvl); end
      checks++; if ({log_port, log_derr, log_padr} !== 15'h0) begin errors++; $display("FAIL rst_head: got %0h expected 0", {log_port, log_derr, log_padr}); end
      checks++; if ({serr_cnt, derr_cnt, drop_cnt} !== 48'h0) begin errors++; $display("FAIL rst_cnt: got %0h expected 0", {serr_cnt, derr_cnt, drop_cnt}); end
      checks++; if ({ovfl, irq} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %0b expected 00", {ovfl, irq}); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single();
      drive(2'b01, 2'b01, 2'b00, 13'h0, 13'h0123);
      tick();
      idle();
      checks++; if (log_vld !== 1'b1)       begin errors++; $display("FAIL single_vld: got %0d expected 1", log_vld); end
      checks++; if (log_port !== 1'b0)      begin errors++; $display("FAIL single_port: got %0d expected 0", log_port); end
      checks++; if (log_derr !== 1'b0)      begin errors++; $display("FAIL single_derr: got %0d expected 0", log_derr); end
      checks++; if (log_padr !== 13'h0123)  begin errors++; $display("FAIL single_padr: got %0h expected 123", log_padr); end
      checks++; if (serr_cnt !== 16'd1)     begin errors++; $display("FAIL single_serr: got %0d expected 1", serr_cnt); end
      checks++; if (log_lvl !== 4'd1)       begin errors++; $display("FAIL single_lvl: got %0d expected 1", log_lvl); end
      checks++; if (irq !== 1'b1)           begin errors++; $display("FAIL single_irq: got %0d expected 1", irq); end
      log_pop = 1'b1;
      tick();
      log_pop = 1'b0;
      checks++; if (log_lvl !== 4'd0)       begin errors++; $display("FAIL single_poplvl: got %0d expected 0", log_lvl); end
      checks++; if ({log_vld, irq} !== 2'b00) begin errors++; $display("FAIL single_popirq: got %0b expected 00", {log_vld, irq}); end
   endtask

   task automatic test_pop_empty();
      log_pop = 1'b1;
      tick();
      log_pop = 1'b0;
      checks++; if (log_lvl !== 4'd0) begin errors++; $display("FAIL popempty_lvl: got %0d expected 0", log_lvl); end
      checks++; if (log_vld !== 1'b0) begin errors++; $display("FAIL popempty_vld: got %0d expected 0", log_vld); end
   endtask

   task automatic test_both();
      drive(2'b11, 2'b10, 2'b01, 13'h0555, 13'h0AAA);
      tick();
      idle();
      checks++; if (log_lvl !== 4'd2) begin errors++; $display("FAIL both_lvl: got %0d expected 2", log_lvl); end
      checks++; if ({log_port, log_derr, log_padr} !== {1'b0, 1'b1, 13'h0AAA}) begin errors++; $display("FAIL both_head0: got %0h expected %0h", {log_port, log_derr, log_padr}, {1'b0, 1'b1, 13'h0AAA}); end
      checks++; if ({serr_cnt, derr_cnt} !== {16'd2, 16'd1}) begin errors++; $display("FAIL both_cnt: got %0h expected 20001", {serr_cnt, derr_cnt}); end
      log_pop = 1'b1;
      tick();
      checks++; if ({log_port, log_derr, log_padr} !== {1'b1, 1'b0, 13'h0555}) begin errors++; $display("FAIL both_head1: got %0h expected %0h", {log_port, log_derr, log_padr}, {1'b1, 1'b0, 13'h0555}); end
      checks++; if (log_lvl !== 4'd1) begin errors++; $display("FAIL both_lvl1: got %0d expected 1", log_lvl); end
      tick();
      log_pop = 1'b0;
      checks++; if (log_lvl !== 4'd0) begin errors++; $display("FAIL both_lvl0: got %0d expected 0", log_lvl); end
   endtask

   task automatic test_full();
      logic [12:0] expPadr [8];
      for (int i = 1; i <= 7; i++) begin
         drive(2'b01, 2'b01, 2'b00, 13'h0, 13'(i));
         tick();
      end
      idle();
      checks++; if (log_lvl !== 4'd7)   begin errors++; $display("FAIL full_lvl7: got %0d expected 7", log_lvl); end
      checks++; if (serr_cnt !== 16'd9) begin errors++; $display("FAIL full_serr9: got %0d expected 9", serr_cnt); end
      drive(2'b11, 2'b11, 2'b00, 13'h0101, 13'h0100);
      tick();
      idle();
      checks++; if (log_lvl !== 4'd8)    begin errors++; $display("FAIL full_lvl8: got %0d expected 8", log_lvl); end
      checks++; if (drop_cnt !== 16'd1)  begin errors++; $display("FAIL full_drop1: got %0d expected 1", drop_cnt); end
      checks++; if ({ovfl, irq} !== 2'b11) begin errors++; $display("FAIL full_ovfl: got %0b expected 11", {ovfl, irq}); end
      checks++; if (serr_cnt !== 16'd11) begin errors++; $display("FAIL full_serr11: got %0d expected 11", serr_cnt); end
      drive(2'b11, 2'b11, 2'b00, 13'h0201, 13'h0200);
      log_pop = 1'b1;
      tick();
      log_pop = 1'b0;
      idle();
      checks++; if (log_lvl !== 4'd8)    begin errors++; $display("FAIL fullpop_lvl: got %0d expected 8", log_lvl); end
      checks++; if (drop_cnt !== 16'd2)  begin errors++; $display("FAIL fullpop_drop: got %0d expected 2", drop_cnt); end
      checks++; if (serr_cnt !== 16'd13) begin errors++; $display("FAIL fullpop_serr: got %0d expected 13", serr_cnt); end
      checks++; if (log_padr !== 13'h2)  begin errors++; $display("FAIL fullpop_head: got %0h expected 2", log_padr); end
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      checks++; if ({serr_cnt, derr_cnt, drop_cnt} !== 48'h0) begin errors++; $display("FAIL clr_cnt: got %0h expected 0", {serr_cnt, derr_cnt, drop_cnt}); end
      checks++; if ({ovfl, irq, log_lvl} !== {1'b0, 1'b1, 4'd8}) begin errors++; $display("FAIL clr_flags: got %0h expected %0h", {ovfl, irq, log_lvl}, {1'b0, 1'b1, 4'd8}); end
      expPadr = '{13'h2, 13'h3, 13'h4, 13'h5, 13'h6, 13'h7, 13'h100, 13'h200};
      for (int i = 0; i < 8; i++) begin
         checks++; if (log_padr !== expPadr[i]) begin errors++; $display("FAIL drain_%0d: got %0h expected %0h", i, log_padr, expPadr[i]); end
         log_pop = 1'b1;
         tick();
         log_pop = 1'b0;
      end
      checks++; if ({log_vld, irq, log_lvl} !== 6'h0) begin errors++; $display("FAIL drain_end: got %0h expected 0", {log_vld, irq, log_lvl}); end
   endtask

   task automatic test_sat();
      drive(2'b11, 2'b11, 2'b00, 13'h0022, 13'h0011);
      repeat (40000) @(posedge clk);
      #1;
      checks++; if (serr_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_serr: got %0h expected ffff", serr_cnt); end
      checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_drop: got %0h expected ffff", drop_cnt); end
      checks++; if ({derr_cnt, log_lvl, ovfl} !== {16'd0, 4'd8, 1'b1}) begin errors++; $display("FAIL sat_misc: got %0h expected %0h", {derr_cnt, log_lvl, ovfl}, {16'd0, 4'd8, 1'b1}); end
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      idle();
      checks++; if ({serr_cnt, drop_cnt} !== 32'h0) begin errors++; $display("FAIL satclr_cnt: got %0h expected 0", {serr_cnt, drop_cnt}); end
      checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL satclr_ovfl: got %0d expected 0", ovfl); end
   endtask

   task automatic test_rst_mid();
      #2 rst = 1'b0;
      #1;
      checks++; if (log_lvl !== 4'd0) begin errors++; $display("FAIL rstmid_empty: got %0d expected 0", log_lvl); end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(2'b01, 2'b00, 2'b01, 13'h0, 13'(16 + i));
         tick();
      end
      checks++; if ({log_lvl, derr_cnt} !== {4'd5, 16'd5}) begin errors++; $display("FAIL rstmid_fill: got %0h expected %0h", {log_lvl, derr_cnt}, {4'd5, 16'd5}); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({log_vld, log_port, log_derr, log_padr, log_lvl} !== 20'h0) begin errors++; $display("FAIL rstmid_fifo: got %0h expected 0", {log_vld, log_port, log_derr, log_padr, log_lvl}); end
      checks++; if ({serr_cnt, derr_cnt, drop_cnt, ovfl, irq} !== 50'h0) begin errors++; $display("FAIL rstmid_cnt: got %0h expected 0", {serr_cnt, derr_cnt, drop_cnt, ovfl, irq}); end
      tick();
      checks++; if ({log_lvl, derr_cnt, irq} !== 21'h0) begin errors++; $display("FAIL rstmid_hold: got %0h expected 0", {log_lvl, derr_cnt, irq}); end
      idle();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_ready();
      ready = 1'b0;
      drive(2'b11, 2'b11, 2'b01, 13'h0333, 13'h0444);
      repeat (3) tick();
      idle();
      ready = 1'b1;
      tick();
      checks++; if ({log_vld, log_lvl} !== 5'h0) begin errors++; $display("FAIL ready_fifo: got %0h expected 0", {log_vld, log_lvl}); end
      checks++; if ({serr_cnt, derr_cnt, drop_cnt} !== 48'h0) begin errors++; $display("FAIL ready_cnt: got %0h expected 0", {serr_cnt, derr_cnt, drop_cnt}); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ready_irq: got %0d expected 0", irq); end
   endtask

   task automatic test_dual_flag();
      drive(2'b10, 2'b10, 2'b10, 13'h1FFF, 13'h0);
      tick();
      idle();
      checks++; if ({derr_cnt, serr_cnt} !== {16'd1, 16'd0}) begin errors++; $display("FAIL dual_cnt: got %0h expected 10000", {derr_cnt, serr_cnt}); end
      checks++; if ({log_port, log_derr, log_padr} !== {1'b1, 1'b1, 13'h1FFF}) begin errors++; $display("FAIL dual_head: got %0h expected %0h", {log_port, log_derr, log_padr}, {1'b1, 1'b1, 13'h1FFF}); end
      log_pop = 1'b1;
      tick();
      log_pop = 1'b0;
      checks++; if (log_lvl !== 4'd0) begin errors++; $display("FAIL dual_drain: got %0d expected 0", log_lvl); end
   endtask

   initial begin
      rst     = 1'b0;
      ready   = 1'b1;
      log_pop = 1'b0;
      cnt_clr = 1'b0;
      idle();
      test_reset();
      test_single();
      test_pop_empty();
      test_both();
      test_full();
      test_sat();
      test_rst_mid();
      test_ready();
      test_dual_flag();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
